vx_tcu_drl_norm_round: RTL and testbench

- Output end of the TCU dot-product reduction path.
- The upstream max-exponent/alignment stage produces a signed, aligned fixed-point accumulator sum and the shared max exponent. This block converts that pair back into a packed IEEE float.
- Conversion steps: leading-one detect, normalize shift, exponent rebias, round-to-nearest-even, special-case and overflow/underflow handling.
- 3-stage elastic pipeline with valid/ready handshake and tag passthrough.

---
 rtl/vx_tcu_pkg.sv | 32 +++
 rtl/vx_tcu_drl_lzc.sv | 23 ++
 rtl/vx_tcu_drl_norm_round.sv | 145 ++++++++++++++
 tb/tb_vx_tcu_drl_norm_round.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_tcu_pkg.sv
// Shared TCU definitions: default widths, norm-stage latency, canonical NaN and
// the payload carried between the normalize/round pipeline stages.
package vx_tcu_pkg;

    localparam int unsigned TCU_NORM_LATENCY = 3;

    localparam int unsigned TCU_ACC_W     = 48;
    localparam int unsigned TCU_FRAC_BITS = 44;
    localparam int unsigned TCU_EXP_W     = 8;
    localparam int unsigned TCU_MAN_W     = 23;
    localparam int unsigned TCU_BIAS      = 127;
    localparam int unsigned TCU_TAG_W     = 8;

    localparam int unsigned TCU_E_W   = TCU_EXP_W + $clog2(TCU_ACC_W) + 2;
    localparam int unsigned TCU_RES_W = 1 + TCU_EXP_W + TCU_MAN_W;

    localparam logic [TCU_RES_W-1:0] TCU_CANON_NAN =
        {1'b0, {TCU_EXP_W{1'b1}}, 1'b1, {(TCU_MAN_W-1){1'b0}}};

    // mag holds |sum| after S1 and the normalized significand after S2
    typedef struct packed {
        logic                      sign;
        logic                      zero;
        logic                      nan;
        logic                      inf;
        logic                      inf_sign;
        logic signed [TCU_E_W-1:0] e;
        logic [TCU_ACC_W-1:0]      mag;
        logic [TCU_TAG_W-1:0]      tag;
    } tcu_norm_payload_t;

endpackage

// File: rtl/vx_tcu_drl_lzc.sv
// Leading-one detector: reports the index of the most significant set bit and
// whether the input is all zeros.
module vx_tcu_drl_lzc #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned POS_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    output logic [POS_W-1:0] pos,
    output logic             zero
);

    always_comb begin
        pos = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                pos = POS_W'(i);
            end
        end
    end

    assign zero = ~|data;

endmodule

// File: rtl/vx_tcu_drl_norm_round.sv
// Converts the aligned signed accumulator sum and shared exponent into a packed
// IEEE float through a 3-stage elastic pipeline (LZC, normalize, round/pack).
module vx_tcu_drl_norm_round
    import vx_tcu_pkg::*;
#(
    parameter int unsigned ACC_W     = TCU_ACC_W,
    parameter int unsigned FRAC_BITS = TCU_FRAC_BITS,
    parameter int unsigned EXP_W     = TCU_EXP_W,
    parameter int unsigned MAN_W     = TCU_MAN_W,
    parameter int unsigned BIAS      = TCU_BIAS,
    parameter int unsigned TAG_W     = TCU_TAG_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_in,
    output logic                     ready_in,
    input  logic [ACC_W-1:0]         sum_in,
    input  logic [EXP_W-1:0]         max_exp_in,
    input  logic                     nan_in,
    input  logic                     inf_in,
    input  logic                     inf_sign_in,
    input  logic [TAG_W-1:0]         tag_in,
    output logic                     valid_out,
    input  logic                     ready_out,
    output logic [EXP_W+MAN_W:0]     result_out,
    output logic [TAG_W-1:0]         tag_out
);

    localparam int unsigned POS_W = $clog2(ACC_W);
    localparam int unsigned E_W   = EXP_W + POS_W + 2;
    localparam int unsigned RES_W = 1 + EXP_W + MAN_W;
    localparam int unsigned GRD   = ACC_W - 2 - MAN_W;
    localparam logic signed [E_W-1:0] EXP_INF = E_W'((1 << EXP_W) - 1);

    logic                        en;
    logic [TCU_NORM_LATENCY-1:0] vld_q;

    logic [ACC_W-1:0]  mag;
    logic [POS_W-1:0]  lead_pos;
    logic              lead_zero;
    logic [E_W-1:0]    e_unbiased;

    tcu_norm_payload_t s1_d, s1_q;
    tcu_norm_payload_t s2_d, s2_q;
    logic [POS_W-1:0]  s1_pos_q;

    logic [MAN_W-1:0]      mant;
    logic                  guard;
    logic                  sticky;
    logic                  round_up;
    logic [MAN_W:0]        mant_r;
    logic signed [E_W-1:0] e_r;
    logic                  underflow;
    logic [RES_W-1:0]      result_d;
    logic [RES_W-1:0]      result_q;
    logic [TAG_W-1:0]      tag_q;
    logic                  unused_hidden;

    // Whole pipe advances together; only a stalled valid output freezes it.
    assign en         = ~(valid_out & ~ready_out);
    assign ready_in   = en;
    assign valid_out  = vld_q[TCU_NORM_LATENCY-1];
    assign result_out = result_q;
    assign tag_out    = tag_q;

    // S1: sign/magnitude and leading-one position
    assign mag = sum_in[ACC_W-1] ? -sum_in : sum_in;

    vx_tcu_drl_lzc #(
        .WIDTH (ACC_W),
        .POS_W (POS_W)
    ) u_lzc (
        .data (mag),
        .pos  (lead_pos),
        .zero (lead_zero)
    );

    always_comb begin
        e_unbiased = E_W'(max_exp_in) - E_W'(BIAS) + E_W'(lead_pos) - E_W'(FRAC_BITS);
        s1_d          = '0;
        s1_d.sign     = sum_in[ACC_W-1];
        s1_d.zero     = lead_zero;
        s1_d.nan      = nan_in;
        s1_d.inf      = inf_in;
        s1_d.inf_sign = inf_sign_in;
        s1_d.e        = e_unbiased + E_W'(BIAS);
        s1_d.mag      = mag;
        s1_d.tag      = tag_in;
    end

    // S2: move the leading one up to the MSB
    always_comb begin
        s2_d     = s1_q;
        s2_d.mag = s1_q.mag << (POS_W'(ACC_W - 1) - s1_pos_q);
    end

    // S3: round-to-nearest-even, then resolve specials and range
    assign unused_hidden = s2_q.mag[ACC_W-1];

    always_comb begin
        mant      = s2_q.mag[ACC_W-2 -: MAN_W];
        guard     = s2_q.mag[GRD];
        sticky    = |s2_q.mag[GRD-1:0];
        round_up  = guard & (sticky | mant[0]);
        mant_r    = {1'b0, mant} + (MAN_W + 1)'(round_up);
        e_r       = s2_q.e + E_W'(mant_r[MAN_W]);
        underflow = s2_q.e[E_W-1] | (s2_q.e == '0);

        result_d = {s2_q.sign, e_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
        if (s2_q.nan) begin
            result_d = TCU_CANON_NAN;
        end else if (s2_q.inf) begin
            result_d = {s2_q.inf_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s2_q.zero) begin
            result_d = '0;
        end else if (e_r >= EXP_INF) begin
            result_d = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (underflow) begin
            result_d = {s2_q.sign, {(EXP_W + MAN_W){1'b0}}};
        end
    end

    // Data registers load only behind a valid beat so bubbles leave them untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q    <= '0;
            result_q <= '0;
            tag_q    <= '0;
        end else if (en) begin
            vld_q <= {vld_q[TCU_NORM_LATENCY-2:0], valid_in};
            if (valid_in) begin
                s1_q     <= s1_d;
                s1_pos_q <= lead_pos;
            end
            if (vld_q[0]) begin
                s2_q <= s2_d;
            end
            if (vld_q[1]) begin
                result_q <= result_d;
                tag_q    <= s2_q.tag;
            end
        end
    end

endmodule

// File: tb/tb_vx_tcu_drl_norm_round.sv
// Self-checking bench: directed conversions, back-pressure, reset flush and a
// randomized stream scored against a floating-point reference model.
module tb_vx_tcu_drl_norm_round;
    import vx_tcu_pkg::*;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic        ready_in;
    logic [47:0] sum_in;
    logic [7:0]  max_exp_in;
    logic        nan_in;
    logic        inf_in;
    logic        inf_sign_in;
    logic [7:0]  tag_in;
    logic        valid_out;
    logic        ready_out;
    logic [31:0] result_out;
    logic [7:0]  tag_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] res;
        logic [7:0]  tag;
        int          stamp;
    } exp_t;

    exp_t        exp_q[$];
    int          en_edges = 0;
    int          n_out = 0;
    logic [7:0]  tag_ctr = 8'h10;
    bit          rand_ready = 0;

    vx_tcu_drl_norm_round dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .sum_in      (sum_in),
        .max_exp_in  (max_exp_in),
        .nan_in      (nan_in),
        .inf_in      (inf_in),
        .inf_sign_in (inf_sign_in),
        .tag_in      (tag_in),
        .valid_out   (valid_out),
        .ready_out   (ready_out),
        .result_out  (result_out),
        .tag_out     (tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", name, obs, expv);
        end
    endtask

    // Reference: exact value via double precision, then repack to binary32.
    function automatic logic [31:0] ref_model(input logic [47:0] s, input logic [7:0] me,
                                              input logic n, input logic i, input logic is);
        logic            sgn;
        longint          sv;
        longint unsigned m;
        real             v;
        logic [63:0]     b;
        int              ex;
        int              fe;
        logic [22:0]     fm;
        logic            g;
        logic            st;
        logic [23:0]     fmr;
        if (n) return 32'h7FC0_0000;
        if (i) return {is, 8'hFF, 23'h0};
        sgn = s[47];
        sv  = longint'($signed(s));
        m   = sgn ? longint'(-sv) : longint'(sv);
        if (m == 0) return 32'h0;
        v  = real'(m);
        ex = int'(me) - 127 - 44;
        if (ex > 0) for (int k = 0; k < ex; k++) v = v * 2.0;
        else for (int k = 0; k < -ex; k++) v = v / 2.0;
        b  = $realtobits(v);
        fe = int'(b[62:52]) - 1023 + 127;
        fm = b[51:29];
        g  = b[28];
        st = |b[27:0];
        if (fe <= 0) return {sgn, 31'h0};
        fmr = {1'b0, fm} + ((g && (st || fm[0])) ? 24'd1 : 24'd0);
        if (fmr[23]) fe++;
        if (fe >= 255) return {sgn, 8'hFF, 23'h0};
        return {sgn, fe[7:0], fmr[22:0]};
    endfunction

    // Scoreboard: record accepted beats, check every output transfer in order.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (valid_out && ready_out) begin
                n_out++;
                check("out_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_result", result_out, e.res);
                    check("sb_tag", tag_out, e.tag);
                    check("sb_latency", 64'(en_edges - e.stamp), 64'(TCU_NORM_LATENCY));
                end
            end
            if (valid_in && ready_in) begin
                exp_t e;
                e.res   = ref_model(sum_in, max_exp_in, nan_in, inf_in, inf_sign_in);
                e.tag   = tag_in;
                e.stamp = en_edges;
                exp_q.push_back(e);
            end
            if (ready_in) en_edges++;
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) ready_out = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [47:0] s, input logic [7:0] me,
                        input logic n, input logic i, input logic is);
        bit acc;
        int k;
        valid_in    = 1'b1;
        sum_in      = s;
        max_exp_in  = me;
        nan_in      = n;
        inf_in      = i;
        inf_sign_in = is;
        tag_in      = tag_ctr;
        acc = 0;
        k   = 0;
        while (!acc && k < 200) begin
            @(negedge clk);
            acc = ready_in;
            step();
            k++;
        end
        check("send_accepted", 64'(acc), 1);
        tag_ctr++;
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int k;
        k          = 0;
        rand_ready = 0;
        ready_out  = 1'b1;
        valid_in   = 1'b0;
        while (exp_q.size() != 0 && k < 100) begin
            step();
            k++;
        end
        check("drain_empty", 64'(exp_q.size()), 0);
    endtask

    task automatic directed(input string name, input logic [47:0] s, input logic [7:0] me,
                            input logic n, input logic i, input logic is,
                            input logic [31:0] expv);
        logic [7:0] t;
        int         k;
        t = tag_ctr;
        send(s, me, n, i, is);
        k = 0;
        @(negedge clk);
        while (!valid_out && k < 10) begin
            @(negedge clk);
            k++;
        end
        check({name, "_valid"}, 64'(valid_out), 1);
        check(name, result_out, expv);
        check({name, "_tag"}, tag_out, t);
        step();
    endtask

    logic [47:0] bp_s[8];
    logic [31:0] exp0;
    logic [7:0]  tag0;
    int          n_before;
    logic [63:0] r;
    logic [47:0] rs;

    initial begin
        reset       = 1'b1;
        valid_in    = 1'b0;
        sum_in      = '0;
        max_exp_in  = '0;
        nan_in      = 1'b0;
        inf_in      = 1'b0;
        inf_sign_in = 1'b0;
        tag_in      = '0;
        ready_out   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_out", 64'(valid_out), 0);
        check("rst_result", result_out, 0);
        check("rst_tag", tag_out, 0);
        reset = 1'b0;
        step();
        check("rst_ready_in", 64'(ready_in), 1);

        directed("one",       48'd1 << 44, 8'd127, 0, 0, 0, 32'h3F80_0000);
        directed("neg_1p5",   48'd0 - (48'd3 << 43), 8'd127, 0, 0, 0, 32'hBFC0_0000);
        directed("tie_even",  (48'd1 << 44) + (48'd1 << 20), 8'd127, 0, 0, 0, 32'h3F80_0000);
        directed("tie_odd",   (48'd1 << 44) + (48'd1 << 21) + (48'd1 << 20), 8'd127, 0, 0, 0,
                 32'h3F80_0002);
        directed("rnd_carry", (48'd1 << 45) - 48'd1, 8'd127, 0, 0, 0, 32'h4000_0000);
        directed("most_neg",  48'h8000_0000_0000, 8'd127, 0, 0, 0, 32'hC100_0000);
        directed("ovf",       (48'd1 << 47) - 48'd1, 8'd254, 0, 0, 0, 32'h7F80_0000);
        directed("carry_inf", (48'd1 << 45) - 48'd1, 8'd254, 0, 0, 0, 32'h7F80_0000);
        directed("unf",       48'd1, 8'd1, 0, 0, 0, 32'h0000_0000);
        directed("zero",      48'd0, 8'd200, 0, 0, 0, 32'h0000_0000);
        directed("nan",       48'd1 << 44, 8'd127, 1, 1, 1, 32'h7FC0_0000);
        directed("neg_inf",   48'd1 << 44, 8'd127, 0, 1, 1, 32'hFF80_0000);

        // Back-pressure: 3 in flight, stall 5 cycles, then finish the stream.
        for (int k = 0; k < 8; k++) bp_s[k] = (48'(k) + 48'd1) << 42;
        n_before  = n_out;
        ready_out = 1'b1;
        for (int k = 0; k < 3; k++) send(bp_s[k], 8'd130, 0, 0, 0);
        exp0 = ref_model(bp_s[0], 8'd130, 0, 0, 0);
        tag0 = tag_ctr - 8'd3;
        ready_out   = 1'b0;
        valid_in    = 1'b1;
        sum_in      = bp_s[3];
        max_exp_in  = 8'd130;
        tag_in      = tag_ctr;
        repeat (5) begin
            @(negedge clk);
            check("bp_ready_in", 64'(ready_in), 0);
            check("bp_valid_out", 64'(valid_out), 1);
            check("bp_result_hold", result_out, exp0);
            check("bp_tag_hold", tag_out, tag0);
            step();
        end
        ready_out = 1'b1;
        for (int k = 3; k < 8; k++) send(bp_s[k], 8'd130, 0, 0, 0);
        drain();
        check("bp_count", 64'(n_out - n_before), 8);

        // Reset with one beat at the output and one behind it.
        send(48'd5 << 44, 8'd127, 0, 0, 0);
        send(48'd7 << 44, 8'd127, 0, 0, 0);
        step();
        check("pre_rst_valid", 64'(valid_out), 1);
        ready_out = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_valid_out", 64'(valid_out), 0);
        check("mid_rst_result", result_out, 0);
        check("mid_rst_tag", tag_out, 0);
        reset     = 1'b0;
        ready_out = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("no_stale_out", 64'(valid_out), 0);
        end
        step();

        // Randomized stream with random back-pressure and gaps.
        rand_ready = 1;
        for (int n = 0; n < 300; n++) begin
            r  = {$urandom(), $urandom()};
            rs = r[47:0] >> $urandom_range(0, 47);
            if ($urandom_range(0, 1) == 1) rs = 48'd0 - rs;
            case ($urandom_range(0, 15))
                0:       rs = '0;
                1:       rs = 48'h8000_0000_0000;
                2:       rs = (48'd1 << $urandom_range(24, 46)) | (48'd1 << $urandom_range(0, 23));
                default: ;
            endcase
            send(rs, 8'($urandom_range(0, 255)), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) step();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
